regfile_wb_arbiter: RTL

Shares the single register-file write port between the in-order pipeline writeback and one multi-cycle auxiliary unit (divider or load return).
- Pipeline writes always win.
- Aux results are buffered in a small FIFO and committed in idle pipeline write slots.
- A busy-register scoreboard tells decode when an operand or destination is still pending from the aux unit.
- Sits between MEM/WB, the aux unit, and the register file write port.

---
 rtl/regfile_wb_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, aux results drain from a FIFO in idle slots.
// Busy-register scoreboard for decode; optional starvation guard enabled by WB_STARVE_GUARD_EN.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_waddr,
    input  logic [DATA_W-1:0] pipe_wdata,
    input  logic              aux_valid,
    output logic              aux_ready,
    input  logic [ADDR_W-1:0] aux_waddr,
    input  logic [DATA_W-1:0] aux_wdata,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_waddr,
    output logic              issue_ready,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    input  logic              dst_chk,
    input  logic [ADDR_W-1:0] dst_addr,
    output logic              hazard_stall,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              pipe_hold
);

    localparam int unsigned PtrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned NumRegs = 1 << ADDR_W;

    // Reject configurations the pointer arithmetic cannot support.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_param_check
        $error("regfile_wb_arbiter: FIFO_DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
    end

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    wb_entry_t           fifo_q [FIFO_DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [NumRegs-1:0]  busy_q, busy_d;

    wb_entry_t           head;
    logic                fifo_empty;
    logic                fifo_full;
    logic                pipe_win;
    logic                push;
    logic                pop;
    logic                issue_fire;
    logic                haz1, haz2, haz3;

    assign head       = fifo_q[rd_ptr_q];
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
    assign pipe_win   = pipe_we && (pipe_waddr != '0);

    // Head commits only in a slot the pipeline leaves idle; no same-cycle bypass of a fresh push.
    assign pop        = !rst && !pipe_win && !fifo_empty;
    assign aux_ready  = !rst && !fifo_full;
    assign push       = aux_valid && aux_ready && (aux_waddr != '0);

    assign issue_ready = !rst && ((issue_waddr == '0) || !busy_q[issue_waddr]);
    assign issue_fire  = issue_valid && issue_ready && (issue_waddr != '0);

    // The value being committed this cycle reaches decode through the regfile bypass.
    assign haz1 = re1     && busy_q[raddr1]   && !(pop && (head.addr == raddr1));
    assign haz2 = re2     && busy_q[raddr2]   && !(pop && (head.addr == raddr2));
    assign haz3 = dst_chk && busy_q[dst_addr] && !(pop && (head.addr == dst_addr));
    assign hazard_stall = !rst && (haz1 || haz2 || haz3);

    // Write-port mux.
    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        if (!rst) begin
            if (pipe_win) begin
                we    = 1'b1;
                waddr = pipe_waddr;
                wdata = pipe_wdata;
            end else if (!fifo_empty) begin
                we    = 1'b1;
                waddr = head.addr;
                wdata = head.data;
            end
        end
    end

    // FIFO bookkeeping and scoreboard next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        busy_d   = busy_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d          = rd_ptr_q + PtrW'(1);
            busy_d[head.addr] = 1'b0;
        end
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CntW'(1);
        end
        if (issue_fire) begin
            busy_d[issue_waddr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
        end
    end

    // Entry storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{addr: aux_waddr, data: aux_wdata};
        end
    end

`ifdef WB_STARVE_GUARD_EN
    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

    logic [StarveW-1:0] starve_cnt_q, starve_cnt_d;
    logic               pipe_hold_q, pipe_hold_d;

    // Count cycles the head waits; saturate at the limit and hold the pipeline until it drains.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        pipe_hold_d  = pipe_hold_q;
        if (fifo_empty || pop) begin
            starve_cnt_d = '0;
            pipe_hold_d  = 1'b0;
        end else begin
            if (starve_cnt_q != StarveW'(STARVE_LIMIT)) begin
                starve_cnt_d = starve_cnt_q + StarveW'(1);
            end
            pipe_hold_d = (starve_cnt_d == StarveW'(STARVE_LIMIT));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
            pipe_hold_q  <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            pipe_hold_q  <= pipe_hold_d;
        end
    end

    assign pipe_hold = pipe_hold_q && !rst;
`else
    assign pipe_hold = 1'b0;
`endif

endmodule
